// File: rtl/apb_master_if.sv
// Request/response handshake plus APB (AMBA 3) pins for apb_master.
// The master modport is the bridge; the slave modport is requester plus APB slave.
interface apb_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PAddr;
    logic              PWrite;
    logic              PSel;
    logic              PEnable;
    logic [DATA_W-1:0] PWData;
    logic [DATA_W-1:0] PRData;
    logic              PReady;
    logic              PSlvErr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRData, PReady, PSlvErr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PAddr, PWrite, PSel, PEnable, PWData
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRData, PReady, PSlvErr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PAddr, PWrite, PSel, PEnable, PWData
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: request handshake -> SETUP/ACCESS transfer -> response pulse.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         Rst,
    apb_master_if.master bus
);
    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("apb_master: unsupported DATA_W or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic [DATA_W-1:0] pwdata_q;

    // Slave outputs are only meaningful in a completing ACCESS cycle.
    logic sample_en;
    logic timeout;
    assign sample_en = psel_q && penable_q && bus.PReady;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_q;

    assign timeout = (state_q == ACCESS) && !bus.PReady && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            wait_q <= '0;
        end else if (state_q == SETUP) begin
            wait_q <= '0;
        end else if (state_q == ACCESS && !bus.PReady) begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        paddr_q     <= bus.req_addr;
                        pwrite_q    <= bus.req_write;
                        if (bus.req_write) begin
                            pwdata_q <= bus.req_wdata;
                        end
                        psel_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (sample_en || timeout) begin
                        rsp_rdata_q <= (sample_en && !pwrite_q) ? bus.PRData : '0;
                        rsp_err_q   <= sample_en ? bus.PSlvErr : 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PAddr     = paddr_q;
    assign bus.PWrite    = pwrite_q;
    assign bus.PSel      = psel_q;
    assign bus.PEnable   = penable_q;
    assign bus.PWData    = pwdata_q;
endmodule
